// File: rtl/if_mem_pkg.sv
// Shared types and constants for the instruction-fetch memory responder.
package if_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } if_state_e;

  // Data returned alongside an error response.
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  // Width of the wait-state counter (WaitCycles is limited to 0..15).
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/if_mem_array.sv
// Instruction store: one synchronous write port for boot loading and one
// asynchronous read port that the responder samples at request acceptance.
// Kept separate so it can be swapped for an SRAM macro.
module if_mem_array #(
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [Depth];

  // Boot-load write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side end of the fetch address interface: grants one request at a
// time, checks alignment and range, and answers after WaitCycles+1 cycles.
module instr_mem_responder
  import if_mem_pkg::*;
#(
  parameter int unsigned Depth      = 1024,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned WaitCycles = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     load_we_i,
  input  logic [$clog2(Depth)-1:0] load_addr_i,
  input  logic [31:0]              load_wdata_i
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [31:0] SpanBytes = 32'(Depth * 4);
  localparam logic [WAIT_CNT_W-1:0] WaitInit =
    WAIT_CNT_W'((WaitCycles == 0) ? 0 : WaitCycles - 1);

  if_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pend_err_q, pend_err_d;
  logic [31:0]           pend_data_q, pend_data_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0] offset;
  logic        addr_err;
  logic        accept;
  logic [31:0] mem_rdata;
  logic [31:0] acc_data;

  assign offset   = instr_addr_i - BaseAddr;
  assign addr_err = (instr_addr_i[1:0] != 2'b00) || (offset >= SpanBytes);
  assign instr_gnt_o = (state_q == IDLE) && !load_we_i;
  assign accept   = instr_req_i && instr_gnt_o;
  assign acc_data = addr_err ? ERR_DATA : mem_rdata;

  if_mem_array #(
    .Depth(Depth)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (load_we_i),
    .waddr_i (load_addr_i),
    .wdata_i (load_wdata_i),
    .raddr_i (offset[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  // Next-state logic. The word is captured at acceptance into pend_data so
  // later loads cannot disturb an in-flight response; the visible rdata
  // register only updates on entry to RESP so it holds between responses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_err_d  = pend_err_q;
    pend_data_d = pend_data_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_err_d  = addr_err;
          pend_data_d = acc_data;
          if (WaitCycles > 0) begin
            state_d = WAIT;
            cnt_d   = WaitInit;
          end else begin
            state_d = RESP;
            rdata_d = acc_data;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = pend_data_q;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_err_q  <= 1'b0;
      pend_data_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_err_q  <= pend_err_d;
      pend_data_q <= pend_data_d;
      rdata_q     <= rdata_d;
    end
  end

  assign instr_rvalid_o = (state_q == RESP);
  assign instr_err_o    = instr_rvalid_o && pend_err_q;
  assign instr_rdata_o  = rdata_q;

endmodule
